// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA sprite scheduler and its hit-test helper.
package vga_pkg;

    localparam int N_SPRITES = 64;
    localparam int SLOTS     = 16;
    localparam int SPRITE_H  = 16;
    localparam int V_ACTIVE  = 480;

    typedef struct packed {
        logic       enable;
        logic [9:0] y;
        logic [9:0] x;
    } sprite_attr_t;

    typedef struct packed {
        logic [5:0] id;
        logic [9:0] x;
        logic [3:0] row;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/vga_sprite_hit.sv
// Combinational vertical overlap test for one attribute entry against the line being scheduled.
module vga_sprite_hit
    import vga_pkg::*;
(
    input  logic       enable,
    input  logic [9:0] sprite_y,
    input  logic [9:0] line_y,
    output logic       hit,
    output logic [3:0] row
);

    logic [10:0] line_ext;
    logic [10:0] top_ext;
    logic [10:0] bottom_ext;

    // Widening to 11 bits keeps sprites near y=1023 from wrapping onto the top lines.
    assign line_ext   = {1'b0, line_y};
    assign top_ext    = {1'b0, sprite_y};
    assign bottom_ext = top_ext + 11'(SPRITE_H);

    assign hit = enable && (line_ext >= top_ext) && (line_ext < bottom_ext);
    assign row = 4'(line_y - sprite_y);

endmodule

// File: rtl/vga_sprite_scheduler.sv
// Per-line sprite scheduler: scans the attribute table into a shadow slot list, committed at line start.
// Optional macro VGA_SCHED_OVF_STATS_EN adds the OVF_COUNT statistics output.
module vga_sprite_scheduler
    import vga_pkg::*;
(
    input  logic                 VGA_CLK,
    input  logic                 VGA_RESET_N,
    input  logic                 VGA_LINE_START,
    input  logic [9:0]           VGA_NEXT_Y,
    input  logic                 WR_VALID,
    output logic                 WR_READY,
    input  logic [5:0]           WR_ADDR,
    input  logic [20:0]          WR_DATA,
    output logic [SLOTS-1:0]     SLOT_VALID,
    output logic [SLOTS*6-1:0]   SLOT_ID,
    output logic [SLOTS*10-1:0]  SLOT_X,
    output logic [SLOTS*4-1:0]   SLOT_ROW,
    output logic                 SCAN_BUSY,
    output logic                 OVERFLOW,
`ifdef VGA_SCHED_OVF_STATS_EN
    output logic [15:0]          OVF_COUNT,
`endif
    output logic                 SCAN_LATE
);

    sched_state_t     state;
    logic [5:0]       index;
    logic [9:0]       line_y;
    sprite_attr_t     table_q [N_SPRITES];
    sprite_attr_t     cur_attr;
    slot_t            shadow [SLOTS];
    logic [4:0]       fill;
    logic             shadow_ovf;
    slot_t            out_slot [SLOTS];
    logic [SLOTS-1:0] out_valid;
    logic             scan_busy;
    logic             scan_late;
    logic             wr_ready;
    logic             overflow;
    logic             hit;
    logic [3:0]       hit_row;

    assign cur_attr = table_q[index];

    vga_sprite_hit u_hit (
        .enable   (cur_attr.enable),
        .sprite_y (cur_attr.y),
        .line_y   (line_y),
        .hit      (hit),
        .row      (hit_row)
    );

    // Writes are only accepted outside SCAN, so a scan always sees a stable table.
    always_ff @(posedge VGA_CLK or negedge VGA_RESET_N) begin
        if (!VGA_RESET_N) begin
            for (int i = 0; i < N_SPRITES; i++) table_q[i] <= '0;
        end else if (WR_VALID && wr_ready) begin
            table_q[WR_ADDR] <= sprite_attr_t'(WR_DATA);
        end
    end

    always_ff @(posedge VGA_CLK or negedge VGA_RESET_N) begin
        if (!VGA_RESET_N) begin
            state      <= IDLE;
            index      <= '0;
            line_y     <= '0;
            fill       <= '0;
            shadow_ovf <= 1'b0;
            out_valid  <= '0;
            scan_busy  <= 1'b0;
            scan_late  <= 1'b0;
            wr_ready   <= 1'b1;
            overflow   <= 1'b0;
            for (int k = 0; k < SLOTS; k++) begin
                shadow[k]   <= '0;
                out_slot[k] <= '0;
            end
        end else begin
            scan_late <= 1'b0;
            if (VGA_LINE_START) begin
                // A line start mid-scan commits whatever has been gathered so far.
                for (int k = 0; k < SLOTS; k++) begin
                    out_valid[k] <= (5'(k) < fill);
                    out_slot[k]  <= (5'(k) < fill) ? shadow[k] : '0;
                end
                overflow   <= shadow_ovf;
                scan_late  <= (state == SCAN);
                fill       <= '0;
                shadow_ovf <= 1'b0;
                line_y     <= VGA_NEXT_Y;
                index      <= '0;
                if (VGA_NEXT_Y >= 10'(V_ACTIVE)) begin
                    state     <= DONE;
                    scan_busy <= 1'b0;
                    wr_ready  <= 1'b1;
                end else begin
                    state     <= SCAN;
                    scan_busy <= 1'b1;
                    wr_ready  <= 1'b0;
                end
            end else if (state == SCAN) begin
                // Ascending index order makes slot 0 the highest-priority sprite.
                if (hit) begin
                    if (fill < 5'(SLOTS)) begin
                        shadow[fill[3:0]] <= '{id: index, x: cur_attr.x, row: hit_row};
                        fill              <= fill + 5'd1;
                    end else begin
                        shadow_ovf <= 1'b1;
                    end
                end
                index <= index + 6'd1;
                if (index == 6'(N_SPRITES - 1)) begin
                    state     <= DONE;
                    scan_busy <= 1'b0;
                    wr_ready  <= 1'b1;
                end
            end
        end
    end

`ifdef VGA_SCHED_OVF_STATS_EN
    logic [15:0] ovf_count;

    // Truncated scans count as overflow events too, since sprites may have been lost.
    always_ff @(posedge VGA_CLK or negedge VGA_RESET_N) begin
        if (!VGA_RESET_N) begin
            ovf_count <= '0;
        end else if (VGA_LINE_START && (shadow_ovf || (state == SCAN)) && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end

    assign OVF_COUNT = ovf_count;
`endif

    always_comb begin
        SLOT_ID  = '0;
        SLOT_X   = '0;
        SLOT_ROW = '0;
        for (int k = 0; k < SLOTS; k++) begin
            SLOT_ID[k*6 +: 6]   = out_slot[k].id;
            SLOT_X[k*10 +: 10]  = out_slot[k].x;
            SLOT_ROW[k*4 +: 4]  = out_slot[k].row;
        end
    end

    assign SLOT_VALID = out_valid;
    assign SCAN_BUSY  = scan_busy;
    assign SCAN_LATE  = scan_late;
    assign WR_READY   = wr_ready;
    assign OVERFLOW   = overflow;

endmodule

// File: tb/tb_vga_sprite_scheduler.sv
// Self-checking bench for vga_sprite_scheduler: line-level reference model plus directed literal checks.
module tb_vga_sprite_scheduler;

    logic         clk;
    logic         rst_n;
    logic         line_start;
    logic [9:0]   next_y;
    logic         wr_valid;
    logic         wr_ready;
    logic [5:0]   wr_addr;
    logic [20:0]  wr_data;
    logic [15:0]  slot_valid;
    logic [95:0]  slot_id;
    logic [159:0] slot_x;
    logic [63:0]  slot_row;
    logic         scan_busy;
    logic         overflow;
    logic         scan_late;
`ifdef VGA_SCHED_OVF_STATS_EN
    logic [15:0]  ovf_count;
`endif

    int checks = 0;
    int failures = 0;

    vga_sprite_scheduler dut (
        .VGA_CLK        (clk),
        .VGA_RESET_N    (rst_n),
        .VGA_LINE_START (line_start),
        .VGA_NEXT_Y     (next_y),
        .WR_VALID       (wr_valid),
        .WR_READY       (wr_ready),
        .WR_ADDR        (wr_addr),
        .WR_DATA        (wr_data),
        .SLOT_VALID     (slot_valid),
        .SLOT_ID        (slot_id),
        .SLOT_X         (slot_x),
        .SLOT_ROW       (slot_row),
        .SCAN_BUSY      (scan_busy),
        .OVERFLOW       (overflow),
`ifdef VGA_SCHED_OVF_STATS_EN
        .OVF_COUNT      (ovf_count),
`endif
        .SCAN_LATE      (scan_late)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: remembers the last line start and the table as it stood then,
    // and derives each committed list directly from the overlap rule.
    typedef struct { bit en; int y; int x; } m_attr_t;
    m_attr_t m_table [64];
    m_attr_t m_snap [64];
    bit      m_have_scan;
    int      m_last_ls;
    int      m_last_y;
    int      cyc = 0;
    bit [15:0] e_valid;
    int      e_id [16];
    int      e_x [16];
    int      e_row [16];
    bit      e_ovf;
    bit      e_late;
    bit      e_busy;
    int      e_count;

    function automatic bit m_scanning(input int e);
        return m_have_scan && (m_last_y < 480) && (e > m_last_ls) && (e <= m_last_ls + 64);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                m_table[i] = '{0, 0, 0};
                m_snap[i]  = '{0, 0, 0};
            end
            for (int k = 0; k < 16; k++) begin
                e_id[k] = 0; e_x[k] = 0; e_row[k] = 0;
            end
            m_have_scan = 0;
            m_last_ls = 0;
            m_last_y = 0;
            e_valid = '0;
            e_ovf = 0;
            e_late = 0;
            e_busy = 0;
            e_count = 0;
        end else begin
            bit busy_now;
            int n;
            int hits;
            cyc++;
            busy_now = m_scanning(cyc);
            if (wr_valid && !busy_now)
                m_table[wr_addr] = '{wr_data[20], int'(wr_data[19:10]), int'(wr_data[9:0])};
            e_late = 0;
            if (line_start) begin
                n = 0;
                if (m_have_scan && m_last_y < 480) n = (cyc - m_last_ls - 1 < 64) ? cyc - m_last_ls - 1 : 64;
                hits = 0;
                e_valid = '0;
                e_ovf = 0;
                for (int k = 0; k < 16; k++) begin
                    e_id[k] = 0; e_x[k] = 0; e_row[k] = 0;
                end
                for (int i = 0; i < n; i++) begin
                    if (m_snap[i].en && m_last_y >= m_snap[i].y && m_last_y < m_snap[i].y + 16) begin
                        if (hits < 16) begin
                            e_valid[hits] = 1'b1;
                            e_id[hits] = i;
                            e_x[hits] = m_snap[i].x;
                            e_row[hits] = m_last_y - m_snap[i].y;
                        end else begin
                            e_ovf = 1;
                        end
                        hits++;
                    end
                end
                if ((e_ovf || busy_now) && e_count < 65535) e_count++;
                e_late = busy_now;
                m_snap = m_table;
                m_last_ls = cyc;
                m_last_y = int'(next_y);
                m_have_scan = 1;
            end
            e_busy = m_scanning(cyc + 1);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model, away from the clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            check_output("cyc_scan_busy", 32'(scan_busy), 32'(e_busy));
            check_output("cyc_wr_ready", 32'(wr_ready), 32'(!e_busy));
            check_output("cyc_scan_late", 32'(scan_late), 32'(e_late));
            check_output("cyc_overflow", 32'(overflow), 32'(e_ovf));
            check_output("cyc_slot_valid", 32'(slot_valid), 32'(e_valid));
`ifdef VGA_SCHED_OVF_STATS_EN
            check_output("cyc_ovf_count", 32'(ovf_count), 32'(e_count));
`endif
            for (int k = 0; k < 16; k++) begin
                check_output($sformatf("cyc_slot%0d", k),
                             {12'b0, slot_id[k*6 +: 6], slot_x[k*10 +: 10], slot_row[k*4 +: 4]},
                             e_valid[k] ? 32'((e_id[k] << 14) | (e_x[k] << 4) | e_row[k]) : 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input int y);
        line_start = 1'b1;
        next_y = 10'(y);
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic write_entry(input int addr, input bit en, input int y, input int x);
        wr_valid = 1'b1;
        wr_addr = 6'(addr);
        wr_data = {en, 10'(y), 10'(x)};
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        int wait_cycles;
        rst_n = 1'b0;
        line_start = 1'b0;
        next_y = '0;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        tick(2);
        check_output("reset_slot_valid", 32'(slot_valid), 32'h0);
        check_output("reset_wr_ready", 32'(wr_ready), 32'h1);
        check_output("reset_overflow", 32'(overflow), 32'h0);
        check_output("reset_scan_busy", 32'(scan_busy), 32'h0);
        check_output("reset_scan_late", 32'(scan_late), 32'h0);
        rst_n = 1'b1;
        tick(1);

        $display("[TB] empty table, Y=0");
        apply_stimulus(0);
        check_output("t1_busy_after_start", 32'(scan_busy), 32'h1);
        tick(66);
        check_output("t1_slot_valid", 32'(slot_valid), 32'h0);
        check_output("t1_wr_ready", 32'(wr_ready), 32'h1);

        $display("[TB] two sprites, priority order");
        write_entry(5, 1, 100, 40);
        write_entry(2, 1, 95, 300);
        apply_stimulus(100);
        tick(70);
        apply_stimulus(200);
        check_output("t2_slot_valid", 32'(slot_valid), 32'h3);
        check_output("t2_model_valid", 32'(e_valid), 32'h3);
        check_output("t2_slot0_id", 32'(slot_id[5:0]), 32'd2);
        check_output("t2_slot0_x", 32'(slot_x[9:0]), 32'd300);
        check_output("t2_slot0_row", 32'(slot_row[3:0]), 32'd5);
        check_output("t2_slot1_id", 32'(slot_id[11:6]), 32'd5);
        check_output("t2_slot1_x", 32'(slot_x[19:10]), 32'd40);
        check_output("t2_slot1_row", 32'(slot_row[7:4]), 32'd0);
        tick(70);

        $display("[TB] overflow with 20 sprites");
        for (int i = 0; i < 20; i++) write_entry(i, 1, 10, i * 8);
        apply_stimulus(12);
        tick(70);
        apply_stimulus(300);
        check_output("t3_slot_valid", 32'(slot_valid), 32'hFFFF);
        check_output("t3_overflow", 32'(overflow), 32'h1);
        check_output("t3_slot0_row", 32'(slot_row[3:0]), 32'd2);
        check_output("t3_slot15_id", 32'(slot_id[95:90]), 32'd15);
        check_output("t3_slot15_x", 32'(slot_x[159:150]), 32'd120);
        check_output("t3_model_count", 32'(e_count), 32'd1);
`ifdef VGA_SCHED_OVF_STATS_EN
        check_output("t3_ovf_count", 32'(ovf_count), 32'd1);
`endif
        tick(70);

        $display("[TB] vertical boundaries");
        for (int i = 0; i < 20; i++) write_entry(i, 0, 10, 0);
        write_entry(7, 1, 100, 55);
        write_entry(8, 1, 1020, 1);
        apply_stimulus(115);
        tick(70);
        apply_stimulus(116);
        check_output("t4_y115_valid", 32'(slot_valid), 32'h1);
        check_output("t4_y115_id", 32'(slot_id[5:0]), 32'd7);
        check_output("t4_y115_row", 32'(slot_row[3:0]), 32'd15);
        tick(70);
        apply_stimulus(3);
        check_output("t4_y116_valid", 32'(slot_valid), 32'h0);
        tick(70);
        apply_stimulus(0);
        check_output("t4_nowrap_valid", 32'(slot_valid), 32'h0);
        tick(70);

        $display("[TB] truncated scan");
        write_entry(7, 0, 0, 0);
        write_entry(8, 0, 0, 0);
        write_entry(0, 1, 195, 11);
        write_entry(29, 1, 200, 22);
        write_entry(30, 1, 190, 33);
        apply_stimulus(200);
        tick(30);
        apply_stimulus(201);
        check_output("t5_scan_late", 32'(scan_late), 32'h1);
        check_output("t5_slot_valid", 32'(slot_valid), 32'h3);
        check_output("t5_slot0_id", 32'(slot_id[5:0]), 32'd0);
        check_output("t5_slot0_row", 32'(slot_row[3:0]), 32'd5);
        check_output("t5_slot1_id", 32'(slot_id[11:6]), 32'd29);
        check_output("t5_restart_busy", 32'(scan_busy), 32'h1);
        check_output("t5_model_count", 32'(e_count), 32'd2);
`ifdef VGA_SCHED_OVF_STATS_EN
        check_output("t5_ovf_count", 32'(ovf_count), 32'd2);
`endif
        tick(1);
        check_output("t5_scan_late_drop", 32'(scan_late), 32'h0);
        tick(70);

        $display("[TB] write held across a scan");
        apply_stimulus(50);
        wr_valid = 1'b1;
        wr_addr = 6'd40;
        wr_data = {1'b1, 10'd50, 10'd77};
        wait_cycles = 0;
        while (wr_ready !== 1'b1 && wait_cycles < 200) begin
            @(negedge clk);
            wait_cycles++;
        end
        check_output("t6_ready_wait", 32'(wait_cycles), 32'd64);
        @(negedge clk);
        wr_valid = 1'b0;
        apply_stimulus(50);
        check_output("t6_before_write_valid", 32'(slot_valid), 32'h0);
        tick(70);
        apply_stimulus(470);
        check_output("t6_after_write_valid", 32'(slot_valid), 32'h1);
        check_output("t6_after_write_id", 32'(slot_id[5:0]), 32'd40);
        check_output("t6_after_write_x", 32'(slot_x[9:0]), 32'd77);
        tick(70);
        apply_stimulus(480);
        check_output("t6_y470_valid", 32'(slot_valid), 32'h0);
        check_output("t6_y480_busy", 32'(scan_busy), 32'h0);
        tick(5);
        apply_stimulus(0);
        check_output("t6_y480_empty", 32'(slot_valid), 32'h0);
        tick(70);

        $display("[TB] write coincident with line start");
        wr_valid = 1'b1;
        wr_addr = 6'd0;
        wr_data = {1'b1, 10'd0, 10'd5};
        line_start = 1'b1;
        next_y = 10'd0;
        @(negedge clk);
        wr_valid = 1'b0;
        line_start = 1'b0;
        tick(70);
        apply_stimulus(0);
        check_output("t7_valid", 32'(slot_valid), 32'h1);
        check_output("t7_slot0_id", 32'(slot_id[5:0]), 32'd0);
        check_output("t7_slot0_x", 32'(slot_x[9:0]), 32'd5);

        $display("[TB] reset during scan");
        tick(10);
        rst_n = 1'b0;
        #1;
        check_output("t8_reset_valid", 32'(slot_valid), 32'h0);
        check_output("t8_reset_busy", 32'(scan_busy), 32'h0);
        check_output("t8_reset_ready", 32'(wr_ready), 32'h1);
        tick(2);
        rst_n = 1'b1;
        apply_stimulus(0);
        check_output("t8_discarded_valid", 32'(slot_valid), 32'h0);
        tick(70);
        apply_stimulus(0);
        check_output("t8_table_cleared", 32'(slot_valid), 32'h0);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sprite_scheduler.md
# vga_sprite_scheduler

Per-scanline sprite scheduler for the VGA sprite compositor. It holds a 64-entry sprite attribute table written by game logic, scans the table once per line for sprites overlapping the next scanline, and builds a priority-ordered list of up to `SLOTS` active sprites. The list is double-buffered and swapped at each line start, so the compositor's per-slot object/pixel inputs stay stable for the whole displayed line.

## Interface
- `N_SPRITES`, 64: attribute table depth; fixed by the 6-bit sprite index.
- `SLOTS`, 16: maximum sprites scheduled per line.
- `SPRITE_H`, 16: sprite height in lines.
- `V_ACTIVE`, 480: first non-visible line.
- `VGA_CLK` in 1: pixel clock.
- `VGA_RESET_N` in 1: asynchronous, active-low reset.
- `VGA_LINE_START` in 1: single-cycle pulse at the start of each line.
- `VGA_NEXT_Y` in 10: line to schedule; sampled on `VGA_LINE_START`.
- `WR_VALID` in 1: attribute write request.
- `WR_READY` out 1: write accepted when high together with `WR_VALID`.
- `WR_ADDR` in 6: sprite index.
- `WR_DATA` in 21: `{enable, y[9:0], x[9:0]}`.
- `SLOT_VALID` out SLOTS: slot holds a sprite for the current line.
- `SLOT_ID` out SLOTS×6: sprite index per slot.
- `SLOT_X` out SLOTS×10: sprite x per slot.
- `SLOT_ROW` out SLOTS×4: row within sprite, `VGA_NEXT_Y − y`.
- `SCAN_BUSY` out 1: scan in progress.
- `OVERFLOW` out 1: more than SLOTS sprites hit the committed line.
- `SCAN_LATE` out 1: one-cycle pulse when a line start truncated a scan.

## Operation
- FSM states:
  - IDLE: entered from reset.
  - SCAN: index 0..63, one entry per cycle.
  - DONE: scan complete, shadow list waiting for commit.
- IDLE/DONE + `VGA_LINE_START`:
  - Shadow list → output registers, shadow overflow → `OVERFLOW`.
  - Shadow cleared; `VGA_NEXT_Y` latched; index := 0.
  - If latched Y ≥ V_ACTIVE, go to DONE with the shadow left empty. Otherwise go to SCAN.
- Hit rule for SCAN entry i, with 11-bit unsigned arithmetic: `enable && Y ≥ y && Y < y + SPRITE_H`.
  - A hit with fill count < SLOTS: write `{i, x, (Y−y)[3:0]}` into `shadow[fill]`, then fill++.
  - A hit with fill = SLOTS: set shadow overflow and drop the sprite.
  - Slot 0 always holds the lowest-index hit, so slot order equals compositor priority.
- When index 63 is evaluated, go to DONE.
- SCAN + `VGA_LINE_START` (truncated scan):
  - Commit the partial shadow as-is.
  - Pulse `SCAN_LATE`.
  - Restart SCAN at index 0 with the new Y.
- Writes:
  - `WR_READY` = 1 in IDLE/DONE, 0 in SCAN.
  - Table is updated on the cycle `WR_VALID && WR_READY`.
  - A write in the same cycle as `VGA_LINE_START` lands before the scan reads that entry.
- Reset values:
  - Outputs: all `SLOT_*` = 0, `OVERFLOW` = 0, `SCAN_LATE` = 0, `SCAN_BUSY` = 0, `WR_READY` = 1.
  - Internal: all table entries have enable = 0; FSM = IDLE.
- Reset asserted mid-scan: everything returns to reset values immediately, and the shadow list is discarded.

## Timing
- Line start at cycle t:
  - Outputs show the previous scan's result from t+1.
  - Entry i is evaluated at cycle t+1+i.
  - DONE is reached at t+65.
- Scan needs 64 cycles, well inside an 800-cycle line. Line-to-list latency is one full line, so the game-side Y must be one line ahead.
- `SCAN_BUSY` is high exactly during SCAN cycles.
- `SLOT_*` outputs are registered and change only on the cycle after a line start.

## Configuration
- `VGA_SCHED_OVF_STATS_EN` defined:
  - Adds output `OVF_COUNT` (16 bits, reset 0).
  - Increments on each commit with overflow set; saturates at 16'hFFFF.
  - Also counts truncated scans.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `vga_pkg`:
  - `sprite_attr_t` (`enable`, `y`, `x`) and `slot_t` (`id`, `x`, `row`).
  - Constants V_ACTIVE, SPRITE_H, N_SPRITES, SLOTS.
  - FSM state enum.
- One sub-module, `vga_sprite_hit`: combinational hit test and row computation for a single entry, used by the scan path.

## Test plan
- Reset, then line start with Y=0 and an empty table → after 65 cycles all `SLOT_VALID` = 0 and `WR_READY` = 1.
- Sprites 5 (y=100, x=40) and 2 (y=95, x=300), line start Y=100, second line start → slot0 = {2, 300, row 5}, slot1 = {5, 40, row 0}, `SLOT_VALID` = 16'h0003.
- 20 enabled sprites, all y=10; Y=12 → slots hold indices 0..15, `OVERFLOW` = 1, `OVF_COUNT` = 1 when the macro is enabled.
- Boundary: y=100, Y=115 → hit with row 15. Y=116 → no hit. y=1020, Y=3 → no hit (no wrap).
- Second line start 30 cycles into a scan → `SCAN_LATE` pulses for one cycle, only hits from indices 0..29 are committed, and the new scan restarts.
- `WR_VALID` held during a scan → `WR_READY` = 0 until DONE; the write lands on the first DONE cycle and the entry is used on the next scan. Y=470 → empty list committed.
